// File: rtl/alu_pkg.sv
// Shared ALU definitions: controller state encoding for the bit-serial datapath.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

endpackage : alu_pkg

// File: rtl/fadder.sv
// One-bit full adder cell, shared by the bit-serial adder/subtractor.
module fadder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule : fadder

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial N-bit adder/subtractor: one full-adder cell walks the operands
// LSB first over N cycles, with a start/ready/done handshake around it.
// Subtraction is A + ~B + 1, with the +1 injected as the initial carry.
module serial_addsub_ctrl
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         Ovf
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    ctrl_state_t   r_state;
    ctrl_state_t   w_state_nxt;
    logic [N-1:0]  r_opa;
    logic [N-1:0]  r_opb;
    logic [N-1:0]  r_result;
    logic          r_carry;
    logic [CW-1:0] r_count;
    logic          w_fa_sum;
    logic          w_fa_cout;
    logic          w_last;

    assign w_last = (r_count == LAST_BIT);

    fadder u_fadder (
        .i_a    (r_opa[0]),
        .i_b    (r_opb[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    assign ready = (r_state == IDLE);
    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start is only looked at in IDLE, so it cannot queue.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Serial datapath: capture operands on accept, shift one bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry  <= 1'b0;
            r_count  <= '0;
            r_result <= '0;
        end else if (r_state == IDLE && start) begin
            r_opa    <= A;
            r_opb    <= B ^ {N{sub}};
            r_carry  <= sub;
            r_count  <= '0;
            r_result <= '0;
        end else if (r_state == RUN) begin
            r_result <= {w_fa_sum, r_result[N-1:1]};
            r_opa    <= {1'b0, r_opa[N-1:1]};
            r_opb    <= {1'b0, r_opb[N-1:1]};
            r_carry  <= w_fa_cout;
            if (!w_last) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Result outputs update only on the final RUN edge and hold until the next one.
    // On that edge r_carry is the carry into the MSB and w_fa_cout the carry out.
    always_ff @(posedge clk) begin
        if (rst) begin
            Sum  <= '0;
            Cout <= 1'b0;
            Ovf  <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            Sum  <= {w_fa_sum, r_result[N-1:1]};
            Cout <= w_fa_cout;
            Ovf  <= r_carry ^ w_fa_cout;
        end
    end

endmodule : serial_addsub_ctrl

// File: tb/tb_serial_addsub_ctrl.sv
// Testbench for serial_addsub_ctrl: vector table plus hand-written
// sequences for abort, ignored start and back-to-back operation.
module tb_serial_addsub_ctrl;

    localparam int N = 32;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         s;
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic         ready, busy, done, Cout, Ovf;
    logic [N-1:0] Sum;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc_cnt = 0;
    int   last_done = 0;
    int   prev_done = 0;
    exp_t sb_q[$];
    exp_t last_exp = '{sum: '0, cout: 1'b0, ovf: 1'b0};
    vec_t tbl[10];

    serial_addsub_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout),
        .Ovf   (Ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        exp_t e;
        logic [N-1:0] bx;
        logic [N:0]   t;
        bx = s ? ~b : b;
        t = {1'b0, a} + {1'b0, bx} + {{N{1'b0}}, s};
        e.sum  = t[N-1:0];
        e.cout = t[N];
        e.ovf  = (a[N-1] == bx[N-1]) && (t[N-1] != a[N-1]);
        return e;
    endfunction

    // Output monitor: scoreboard on done, one-hot handshake every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("onehot", 64'($countones({ready, busy, done})), 64'd1);
            if (done) begin
                prev_done = last_done;
                last_done = cyc_cnt;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pulse");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sum", 64'(Sum), 64'(e.sum));
                    chk("cout", 64'(Cout), 64'(e.cout));
                    chk("ovf", 64'(Ovf), 64'(e.ovf));
                end
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ready && k < 4 * N);
        chk("ready_wait", 64'(ready), 64'd1);
    endtask

    // Issue one operation; optionally pulse a stray start mid-run at glitch_cyc.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                          input exp_t e, input int glitch_cyc);
        int cyc;
        wait_ready();
        A = a; B = b; sub = s; start = 1'b1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
        chk("sum_hold", 64'(Sum), 64'(last_exp.sum));
        chk("cout_hold", 64'(Cout), 64'(last_exp.cout));
        chk("ovf_hold", 64'(Ovf), 64'(last_exp.ovf));
        cyc = 0;
        while (!done && cyc < N + 10) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == glitch_cyc) begin
                A = 32'h1234_5678; B = 32'h0000_0FFF; sub = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("latency", 64'(cyc), 64'(N));
        last_exp = e;
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{a: 32'd5,          b: 32'd3,          s: 1'b0, sum: 32'h0000_0008, cout: 1'b0, ovf: 1'b0};
        tbl[1] = '{a: 32'd5,          b: 32'd3,          s: 1'b1, sum: 32'h0000_0002, cout: 1'b1, ovf: 1'b0};
        tbl[2] = '{a: 32'd0,          b: 32'd1,          s: 1'b1, sum: 32'hFFFF_FFFF, cout: 1'b0, ovf: 1'b0};
        tbl[3] = '{a: 32'h7FFF_FFFF,  b: 32'd1,          s: 1'b0, sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1};
        tbl[4] = '{a: 32'h8000_0000,  b: 32'd1,          s: 1'b1, sum: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1};
        tbl[5] = '{a: 32'd0,          b: 32'd0,          s: 1'b1, sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b0};
        tbl[6] = '{a: 32'h8000_0000,  b: 32'h8000_0000,  s: 1'b0, sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b1};
        tbl[7] = '{a: 32'hAAAA_AAAA,  b: 32'h5555_5555,  s: 1'b0, sum: 32'hFFFF_FFFF, cout: 1'b0, ovf: 1'b0};
        tbl[8] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  s: 1'b1, sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b0};
        tbl[9] = '{a: 32'd1,          b: 32'h8000_0000,  s: 1'b1, sum: 32'h8000_0001, cout: 1'b0, ovf: 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(Sum), 64'd0);
        chk("rst_cout", 64'(Cout), 64'd0);
        chk("rst_ovf", 64'(Ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 10; i++) begin
            exp_t e;
            e = '{sum: tbl[i].sum, cout: tbl[i].cout, ovf: tbl[i].ovf};
            run_op(tbl[i].a, tbl[i].b, tbl[i].s, e, -1);
        end

        // Stray start mid-run must be ignored
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, '{sum: 32'd0, cout: 1'b1, ovf: 1'b0}, 9);
        repeat (N + 4) @(negedge clk);
        chk("sb_after_glitch", 64'(sb_q.size()), 64'd0);

        // Reset in the middle of RUN aborts without a done pulse
        wait_ready();
        A = 32'h0F0F_0F0F; B = 32'h0101_0101; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("busy_before_abort", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum", 64'(Sum), 64'd0);
        chk("abort_cout", 64'(Cout), 64'd0);
        chk("abort_ovf", 64'(Ovf), 64'd0);
        last_exp = '{sum: '0, cout: 1'b0, ovf: 1'b0};
        repeat (N + 4) @(negedge clk);
        run_op(32'd2, 32'd2, 1'b0, '{sum: 32'd4, cout: 1'b0, ovf: 1'b0}, -1);

        // Back-to-back: second start lands in the first ready cycle
        run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, '{sum: 32'h0001_0000, cout: 1'b0, ovf: 1'b0}, -1);
        run_op(32'h1000_0000, 32'h2000_0000, 1'b1, '{sum: 32'hF000_0000, cout: 1'b0, ovf: 1'b0}, -1);
        chk("b2b_spacing", 64'(last_done - prev_done), 64'(N + 2));

        // Random operands against the arithmetic model
        for (int i = 0; i < 4; i++) begin
            logic [N-1:0] ra, rb;
            logic rs;
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, model(ra, rb, rs), -1);
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_addsub_ctrl

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
Bit-serial N-bit adder/subtractor controller. It sequences one instance of the team's one-bit full adder (fadder) over N cycles, using a carry flip-flop and shift registers. It provides a start/ready/done handshake so a multi-cycle ALU path or a low-area test datapath can share a single full-adder cell. Operands are captured at start; the result is held until the next operation is accepted.

Parameters:
N, 32, operand/result width in bits (N >= 2)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request new operation; accepted only when ready=1
sub  input  1  0 = A+B, 1 = A-B; sampled with start
A  input  N  operand A, sampled with start
B  input  N  operand B, sampled with start
ready  output  1  high in IDLE only
busy  output  1  high in RUN only
done  output  1  one-cycle pulse in DONE state
Sum  output  N  result; valid from done cycle until next accepted start
Cout  output  1  carry out of MSB (for subtract, 1 = no borrow)
Ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it takes priority over all other inputs.
- Reset values: state=IDLE, ready=1, busy=0, done=0, Sum=0, Cout=0, Ovf=0, count=0, carry=0.
- States and transitions:
  - IDLE -> RUN when start=1.
  - RUN -> RUN while count < N-1.
  - RUN -> DONE on the edge where count = N-1.
  - DONE -> IDLE unconditionally.
- Accept (IDLE, start=1 at edge):
  - opA <= A; opB <= B ^ {N{sub}}; carry <= sub; count <= 0; result register <= 0.
  - Sum, Cout and Ovf keep their previous values until the DONE edge.
- RUN, each cycle:
  - fadder inputs: opA[0], opB[0], carry.
  - At the edge: result <= {fa_sum, result[N-1:1]}; opA, opB shift right by 1 (zero fill); carry <= fa_cout; count <= count+1.
  - When count = N-1, also capture cin_msb <= carry (carry into the MSB) and cout_msb <= fa_cout.
- Latency:
  - start sampled at edge 0; RUN occupies cycles 1..N; done=1 in cycle N+1.
  - ready returns in cycle N+2.
  - Throughput is one operation per N+2 cycles.
- Outputs registered on the RUN->DONE edge:
  - Sum <= final result; Cout <= cout_msb; Ovf <= cin_msb ^ cout_msb.
- start while busy or done: ignored; no queuing, no effect on the operation in progress.
- A, B and sub changing after acceptance: no effect.
- Reset mid-RUN or in DONE: abort; return to reset values; no done pulse.
- count width: clog2(N) bits; it never wraps within an operation.
- Exactly one of ready/busy/done is high in every cycle.

Decomposition:
- Shared package (alu_pkg): state enum ctrl_state_t {IDLE, RUN, DONE}, 2-bit.
- One sub-module: fadder (existing one-bit full adder), instantiated once. No other sub-modules.

Test Plan:
- After reset: ready=1, busy=0, done=0, Sum=0, Cout=0, Ovf=0. Then A=5, B=3, sub=0, start -> done in cycle 33 (N=32), Sum=0x00000008, Cout=0, Ovf=0.
- A=5, B=3, sub=1 -> Sum=0x00000002, Cout=1, Ovf=0. Next, A=0, B=1, sub=1 -> Sum=0xFFFFFFFF, Cout=0, Ovf=0.
- A=0x7FFFFFFF, B=1, sub=0 -> Sum=0x80000000, Ovf=1, Cout=0. Next, A=0x80000000, B=1, sub=1 -> Sum=0x7FFFFFFF, Ovf=1, Cout=1.
- A=0xFFFFFFFF, B=1, sub=0 -> Sum=0, Cout=1, Ovf=0. In the same run, pulse start with new operands in cycle 10 -> ignored, result unchanged, single done pulse.
- rst asserted in cycle 15 of RUN -> next cycle: ready=1, Sum=0, no done pulse. A new start afterwards completes normally (A=2, B=2 -> Sum=4).
- Back-to-back: assert start in the first ready cycle after done -> second result is correct and the done pulses are N+2 cycles apart.
